// File: rtl/config_reg_loader.sv
// config_reg_loader: loads NUM_REGS stream words into a register bank; readback verify when CFG_LOADER_VERIFY_EN is defined
module config_reg_loader #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_REGS = 8,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              cfg_valid,
    input  logic [DATA_W-1:0] cfg_data,
    output logic              cfg_ready,
    output logic              reg_write,
    output logic [ADDR_W-1:0] reg_address,
    output logic [DATA_W-1:0] reg_data_in,
    input  logic [DATA_W-1:0] reg_data_out,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] err_addr,
    output logic [3:0]        err_count
);
    typedef enum logic [2:0] {IDLE, LOAD, RD_ADDR, RD_WAIT, FIN} state_t;
`ifdef CFG_LOADER_VERIFY_EN
    localparam state_t AFTER_LOAD = RD_ADDR;
`else
    localparam state_t AFTER_LOAD = FIN;
`endif
    state_t state, state_n;
    logic [ADDR_W-1:0] idx, idx_n, addr_n;
    logic [DATA_W-1:0] din_n;
    logic ready_q, ready_n, write_n, busy_n, done_n;
    logic hs, last, launch;
    assign hs        = ready_q && cfg_valid;
    assign last      = idx == ADDR_W'(NUM_REGS - 1);
    assign launch    = (state == IDLE) && start && !done;
    assign cfg_ready = ready_q && !reset;
`ifdef CFG_LOADER_VERIFY_EN
    logic [1:0] cnt, cnt_n;
    logic chk, mism;
    logic [DATA_W-1:0] shadow [NUM_REGS];
    assign mism = chk && (reg_data_out != shadow[idx]);
`endif
    // Next-state and next-output logic; registers hold unless the current state acts on them
    always_comb begin
        state_n = state;
        idx_n   = idx;
        ready_n = ready_q;
        write_n = 1'b0;
        addr_n  = reg_address;
        din_n   = reg_data_in;
        busy_n  = busy;
        done_n  = 1'b0;
`ifdef CFG_LOADER_VERIFY_EN
        cnt_n   = cnt;
        chk     = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (launch) begin
                    state_n = LOAD;
                    idx_n   = '0;
                    ready_n = 1'b1;
                    busy_n  = 1'b1;
                end
            end
            LOAD: begin
                if (hs) begin
                    write_n = 1'b1;
                    addr_n  = idx;
                    din_n   = cfg_data;
                    idx_n   = last ? '0 : idx + ADDR_W'(1);
                    ready_n = !last;
                    state_n = last ? AFTER_LOAD : LOAD;
                end
            end
`ifdef CFG_LOADER_VERIFY_EN
            RD_ADDR: begin
                addr_n  = idx;
                cnt_n   = 2'(READ_LAT);
                state_n = RD_WAIT;
            end
            RD_WAIT: begin
                cnt_n = cnt - 2'd1;
                if (cnt == 2'd1) begin
                    chk     = 1'b1;
                    idx_n   = last ? '0 : idx + ADDR_W'(1);
                    state_n = last ? FIN : RD_ADDR;
                end
            end
`endif
            FIN: begin
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    // Index and registered bank/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            idx         <= '0;
            ready_q     <= 1'b0;
            reg_write   <= 1'b0;
            reg_address <= '0;
            reg_data_in <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            idx         <= idx_n;
            ready_q     <= ready_n;
            reg_write   <= write_n;
            reg_address <= addr_n;
            reg_data_in <= din_n;
            busy        <= busy_n;
            done        <= done_n;
        end
    end
`ifdef CFG_LOADER_VERIFY_EN
    // Read-latency counter
    always_ff @(posedge clk) begin
        if (reset) cnt <= '0;
        else cnt <= cnt_n;
    end
    // Shadow copy of every accepted word, compared during readback
    always_ff @(posedge clk) begin
        if (hs) shadow[idx] <= cfg_data;
    end
    // Sticky mismatch flag, first failing address, saturating mismatch count
    always_ff @(posedge clk) begin
        if (reset || launch) begin
            error     <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else if (mism) begin
            error     <= 1'b1;
            err_addr  <= error ? err_addr : idx;
            err_count <= err_count + {3'b0, err_count != 4'hf};
        end
    end
`else
    logic unused_rd;
    assign unused_rd = ^reg_data_out;
    assign error     = 1'b0;
    assign err_addr  = '0;
    assign err_count = '0;
`endif
endmodule

// File: tb/tb_config_reg_loader.sv
// tb_config_reg_loader: directed scoreboard bench for config_reg_loader (follows CFG_LOADER_VERIFY_EN)
module tb_config_reg_loader;
    localparam int NR = 8;
    localparam int RL = 1;
`ifdef CFG_LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    // negedges from the one right after the final handshake edge until done is seen
    localparam int DONE_LAT = VERIFY ? 2 + NR * (RL + 1) : 2;
    localparam int START_AT = VERIFY ? 4 : 1;

    logic clk = 1'b0;
    logic reset, start, cfg_valid, cfg_ready, reg_write, busy, done, error, fault_en;
    logic [15:0] cfg_data, reg_data_in, reg_data_out;
    logic [2:0] reg_address, err_addr;
    logic [3:0] err_count;
    logic [15:0] bank [8];
    logic [18:0] exp_q [$];
    logic [18:0] mon_want;
    int checks = 0;
    int errors = 0;

    logic [15:0] w_good [8] = '{16'h2025, 16'h0001, 16'h00FF, 16'h1234, 16'hA5A5, 16'h5A5A, 16'hFFFF, 16'h0000};
    logic [15:0] w_alt  [8] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};

    always #5 clk = ~clk;

    config_reg_loader #(.DATA_W(16), .ADDR_W(3), .NUM_REGS(NR), .READ_LAT(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .reg_write(reg_write), .reg_address(reg_address),
        .reg_data_in(reg_data_in), .reg_data_out(reg_data_out), .busy(busy), .done(done),
        .error(error), .err_addr(err_addr), .err_count(err_count)
    );

    // Register bank model; fault_en corrupts readback of addresses 3 and 6
    always @(posedge clk) if (reg_write) bank[reg_address] <= reg_data_in;
    assign reg_data_out = (fault_en && reg_address == 3'd3) ? 16'h1235 :
                          (fault_en && reg_address == 3'd6) ? 16'h0000 : bank[reg_address];

    // Every write strobe must match the oldest accepted word
    always @(negedge clk) begin
        if (reg_write) begin
            mon_want = 'x;
            if (exp_q.size() > 0) mon_want = exp_q.pop_front();
            checks++;
            assert ({reg_address, reg_data_in} === mon_want) else begin
                errors++;
                $error("FAIL write: observed %0h expected %0h", {reg_address, reg_data_in}, mon_want);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic run_load(input logic [15:0] w [8], input int gap_at, input int gap_len,
                            input int start_at, input bit start_on_done);
        int n_done, first_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("ready_after_start", cfg_ready, 1);
        check("err_cleared", {error, err_addr, err_count}, 0);
        for (int i = 0; i < NR; i++) begin
            if (i == gap_at) begin
                cfg_valid = 1'b0;
                for (int j = 0; j < gap_len; j++) begin
                    tick();
                    check("gap_no_write", reg_write, 0);
                    check("gap_hold", {reg_address, reg_data_in}, {3'(i - 1), w[i - 1]});
                end
            end
            cfg_valid = 1'b1;
            cfg_data  = w[i];
            check("ready_in_load", cfg_ready, 1);
            if (cfg_ready) exp_q.push_back({3'(i), w[i]});
            tick();
        end
        cfg_valid = 1'b0;
        check("ready_drop", cfg_ready, 0);
        n_done = 0;
        first_done = -1;
        for (int t = 1; t <= DONE_LAT + 3; t++) begin
            if (done) begin
                n_done++;
                if (first_done < 0) first_done = t;
                check("done_busy_low", busy, 0);
            end
            if (start_on_done && first_done > 0 && t == first_done + 1) check("start_in_done_ignored", busy, 0);
            if (start_on_done && first_done > 0 && t == first_done + 2) check("start_after_done_taken", busy, 1);
            start = (t == start_at) || (start_on_done && first_done > 0);
            tick();
        end
        start = 1'b0;
        check("done_latency", first_done, DONE_LAT);
        check("done_once", n_done, 1);
        check("writes_drained", exp_q.size(), 0);
        if (!start_on_done) check("idle_after_done", busy, 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        cfg_valid = 1'b0;
        cfg_data = '0;
        fault_en = 1'b0;
        tick();
        check("reset_outputs", {cfg_ready, reg_write, reg_address, reg_data_in, busy, done, error, err_addr, err_count}, 0);
        tick();
        check("start_during_reset", busy, 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        check("idle_outputs", {cfg_ready, busy, done}, 0);

        run_load(w_good, -1, 0, 0, 1'b0);
        check("good_error", {error, err_addr, err_count}, 0);

        fault_en = 1'b1;
        run_load(w_good, -1, 0, 0, 1'b0);
        check("fault_error", error, VERIFY ? 1 : 0);
        check("fault_err_addr", err_addr, VERIFY ? 3 : 0);
        check("fault_err_count", err_count, VERIFY ? 2 : 0);
        fault_en = 1'b0;

        run_load(w_alt, 2, 3, 0, 1'b0);
        check("stall_error", {error, err_addr, err_count}, 0);

        run_load(w_good, -1, 0, START_AT, 1'b0);
        check("ignored_start_error", {error, err_addr, err_count}, 0);

        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = w_alt[i];
            exp_q.push_back({3'(i), w_alt[i]});
            tick();
        end
        check("mid_load_busy", busy, 1);
        reset = 1'b1;
        cfg_data = w_alt[4];
        #1;
        check("ready_low_in_reset", cfg_ready, 0);
        tick();
        check("abort_outputs", {reg_write, busy, cfg_ready, done}, 0);
        reset = 1'b0;
        cfg_valid = 1'b0;
        tick();
        check("abort_idle", {busy, cfg_ready, reg_write}, 0);

        run_load(w_alt, -1, 0, 0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("final_reset", {busy, reg_write}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
